match_sequencer: RTL and testbench

Match-level controller that sequences the Pong point datapath.
- Detects the start button, runs a frame-timed serve countdown, and issues the one-cycle `start_pt` pulse to the point FSM.
- Watches the point FSM and scores to declare match over and the winner.
- Implements pause by gating the frame tick fed to ball/paddle/point logic.
- Sits between the VGA frame-done source/buttons and the Pong top.

---
 rtl/match_sequencer_if.sv | 30 +++
 rtl/match_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_match_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/match_sequencer_if.sv
// Signal bundle between the Pong match sequencer and the frame source, buttons and point logic.
// The sequencer uses the slave modport; the surrounding Pong top uses the master modport.
interface match_sequencer_if;
    logic       frame_done;
    logic       start_btn;
    logic       pause_btn;
    logic [1:0] pt_state;
    logic [3:0] p1_points;
    logic [3:0] p2_points;
    logic       start_pt;
    logic       frame_tick;
    logic       clear_scores;
    logic [1:0] countdown;
    logic       paused;
    logic       match_over;
    logic       winner;
    logic [2:0] seq_state;

    modport master (
        output frame_done, start_btn, pause_btn, pt_state, p1_points, p2_points,
        input  start_pt, frame_tick, clear_scores, countdown, paused, match_over, winner,
               seq_state
    );

    modport slave (
        input  frame_done, start_btn, pause_btn, pt_state, p1_points, p2_points,
        output start_pt, frame_tick, clear_scores, countdown, paused, match_over, winner,
               seq_state
    );
endinterface

// File: rtl/match_sequencer.sv
// Pong match controller: serve countdown, start_pt pulse, pause gating, match-over detection.
// Define MATCH_ATTRACT_TIMEOUT_EN to return from GAME_OVER to ATTRACT after OVER_FRAMES ticks.
module match_sequencer #(
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned CD_STEPS     = 3,
    parameter int unsigned COUNT_FRAMES = 60,
    parameter int unsigned OVER_FRAMES  = 240
) (
    input logic              clock,
    input logic              reset,
    match_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        StAttract   = 3'd0,
        StCountdown = 3'd1,
        StRally     = 3'd2,
        StScoreChk  = 3'd3,
        StGameOver  = 3'd4,
        StPaused    = 3'd5
    } state_e;

    localparam logic [1:0] StepInit = 2'(CD_STEPS);
    localparam logic [7:0] CntLast  = 8'(COUNT_FRAMES - 1);
    localparam logic [3:0] WinPts   = 4'(WIN_SCORE);

    if (WIN_SCORE < 1 || WIN_SCORE > 9) begin : g_bad_win_score
        $error("WIN_SCORE must lie in 1..9");
    end
    if (CD_STEPS < 1 || CD_STEPS > 3) begin : g_bad_cd_steps
        $error("CD_STEPS must lie in 1..3");
    end
    if (COUNT_FRAMES < 1 || COUNT_FRAMES > 255) begin : g_bad_count_frames
        $error("COUNT_FRAMES must lie in 1..255");
    end
    if (OVER_FRAMES < 1 || OVER_FRAMES > 255) begin : g_bad_over_frames
        $error("OVER_FRAMES must lie in 1..255");
    end

    state_e     state;
    state_e     ret_state;
    logic [1:0] step;
    logic [7:0] frame_cnt;
    logic       start_q;
    logic       pause_q;
    logic [1:0] prev_pt;
    logic       start_pt;
    logic       clear_scores;
    logic       winner;
`ifdef MATCH_ATTRACT_TIMEOUT_EN
    localparam logic [7:0] OverLast = 8'(OVER_FRAMES - 1);
    logic [7:0] over_cnt;
`endif

    logic start_edge;
    logic pause_edge;
    logic paused;

    assign start_edge = bus.start_btn & ~start_q;
    assign pause_edge = bus.pause_btn & ~pause_q;
    assign paused     = (state == StPaused);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= StAttract;
            ret_state    <= StAttract;
            step         <= 2'd0;
            frame_cnt    <= 8'd0;
            start_q      <= 1'b0;
            pause_q      <= 1'b0;
            prev_pt      <= 2'd0;
            start_pt     <= 1'b0;
            clear_scores <= 1'b0;
            winner       <= 1'b0;
`ifdef MATCH_ATTRACT_TIMEOUT_EN
            over_cnt     <= 8'd0;
`endif
        end else begin
            start_q      <= bus.start_btn;
            pause_q      <= bus.pause_btn;
            // Keeps tracking while paused so a point finished during the pause is not lost.
            prev_pt      <= bus.pt_state;
            start_pt     <= 1'b0;
            clear_scores <= 1'b0;

            case (state)
                StAttract: begin
                    if (start_edge) begin
                        clear_scores <= 1'b1;
                        step         <= StepInit;
                        frame_cnt    <= 8'd0;
                        winner       <= 1'b0;
                        state        <= StCountdown;
                    end
                end

                StCountdown: begin
                    // A pause edge takes precedence and its frame_done is dropped.
                    if (pause_edge) begin
                        ret_state <= StCountdown;
                        state     <= StPaused;
                    end else if (bus.frame_done) begin
                        if (frame_cnt == CntLast) begin
                            frame_cnt <= 8'd0;
                            step      <= step - 2'd1;
                            if (step == 2'd1) begin
                                start_pt <= 1'b1;
                                state    <= StRally;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end

                StRally: begin
                    if (pause_edge) begin
                        ret_state <= StRally;
                        state     <= StPaused;
                    end else if (prev_pt == 2'd2 && bus.pt_state == 2'd0) begin
                        state <= StScoreChk;
                    end
                end

                StScoreChk: begin
                    if (bus.p1_points >= WinPts) begin
                        winner <= 1'b0;
                        state  <= StGameOver;
                    end else if (bus.p2_points >= WinPts) begin
                        winner <= 1'b1;
                        state  <= StGameOver;
                    end else begin
                        step      <= StepInit;
                        frame_cnt <= 8'd0;
                        state     <= StCountdown;
                    end
`ifdef MATCH_ATTRACT_TIMEOUT_EN
                    over_cnt <= 8'd0;
`endif
                end

                StGameOver: begin
                    if (start_edge) begin
                        clear_scores <= 1'b1;
                        step         <= StepInit;
                        frame_cnt    <= 8'd0;
                        winner       <= 1'b0;
                        state        <= StCountdown;
`ifdef MATCH_ATTRACT_TIMEOUT_EN
                    end else if (bus.frame_done) begin
                        if (over_cnt == OverLast) begin
                            over_cnt <= 8'd0;
                            winner   <= 1'b0;
                            state    <= StAttract;
                        end else begin
                            over_cnt <= over_cnt + 8'd1;
                        end
`endif
                    end
                end

                StPaused: begin
                    if (pause_edge) begin
                        // Point ended while paused: prev_pt already saw finish_pt, so the
                        // completion edge will not recur in RALLY.
                        if (ret_state == StRally && bus.pt_state == 2'd0) begin
                            state <= StScoreChk;
                        end else begin
                            state <= ret_state;
                        end
                    end
                end

                default: state <= StAttract;
            endcase
        end
    end

    assign bus.start_pt     = start_pt;
    assign bus.clear_scores = clear_scores;
    assign bus.frame_tick   = bus.frame_done & ~paused;
    assign bus.paused       = paused;
    assign bus.match_over   = (state == StGameOver);
    assign bus.winner       = winner;
    assign bus.seq_state    = state;
    // step is zero once the serve has happened, so a paused rally shows no countdown.
    assign bus.countdown    = (state == StCountdown || state == StPaused) ? step : 2'd0;

endmodule

// File: tb/tb_match_sequencer.sv
// Scoreboard bench for match_sequencer: a frame-count model predicts status and pulses per
// cycle; a monitor compares them against the DUT one time unit after each rising edge.
module tb_match_sequencer;

    localparam int Win  = 9;
    localparam int Cd   = 3;
    localparam int Cf   = 2;
    localparam int Over = 4;
`ifdef MATCH_ATTRACT_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    localparam int PhAttract = 0;
    localparam int PhCount   = 1;
    localparam int PhRally   = 2;
    localparam int PhScore   = 3;
    localparam int PhOver    = 4;
    localparam int PhPaused  = 5;

    logic clock;
    logic reset;

    match_sequencer_if bus ();

    match_sequencer #(
        .WIN_SCORE    (Win),
        .CD_STEPS     (Cd),
        .COUNT_FRAMES (Cf),
        .OVER_FRAMES  (Over)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         at;
        logic [7:0] st;
        bit         sp;
        bit         cs;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    // Model: frames still to count before the serve, plus the match phase.
    int m_phase     = PhAttract;
    int m_ret       = PhAttract;
    int m_left      = 0;
    int m_over_left = 0;
    int m_ppt       = 0;
    bit m_winner    = 1'b0;
    bit m_ps        = 1'b0;
    bit m_pp        = 1'b0;
    bit m_valid     = 1'b0;

    logic [1:0] pt     = 2'd0;
    logic [3:0] p1     = 4'd0;
    logic [3:0] p2     = 4'd0;
    bit         serve  = 1'b0;
    bit         sb_lvl = 1'b0;
    bit         pb_lvl = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, act, exp);
    endtask

    task automatic new_match(output bit cs);
        cs       = 1'b1;
        m_left   = Cd * Cf;
        m_phase  = PhCount;
        m_winner = 1'b0;
        p1       = 4'd0;
        p2       = 4'd0;
    endtask

    task automatic drive(input bit r, input bit fd, input bit sb, input bit pb);
        bit   se;
        bit   pe;
        bit   sp;
        bit   cs;
        int   cd;
        exp_t e;
        @(negedge clock);
        reset          = r;
        bus.frame_done = fd;
        bus.start_btn  = sb;
        bus.pause_btn  = pb;
        bus.pt_state   = pt;
        bus.p1_points  = p1;
        bus.p2_points  = p2;
        #1;
        if (m_valid) check("frame_tick", int'(bus.frame_tick), int'(fd && m_phase != PhPaused));
        sp = 1'b0;
        cs = 1'b0;
        if (r) begin
            m_phase  = PhAttract;
            m_ret    = PhAttract;
            m_left   = 0;
            m_winner = 1'b0;
            m_ps     = 1'b0;
            m_pp     = 1'b0;
            m_ppt    = 0;
            m_valid  = 1'b1;
            serve    = 1'b0;
        end else begin
            se = sb && !m_ps;
            pe = pb && !m_pp;
            case (m_phase)
                PhAttract: if (se) new_match(cs);
                PhCount: begin
                    if (pe) begin
                        m_ret   = PhCount;
                        m_phase = PhPaused;
                    end else if (fd) begin
                        m_left--;
                        if (m_left == 0) begin
                            sp      = 1'b1;
                            serve   = 1'b1;
                            m_phase = PhRally;
                        end
                    end
                end
                PhRally: begin
                    if (pe) begin
                        m_ret   = PhRally;
                        m_phase = PhPaused;
                    end else if (m_ppt == 2 && pt == 2'd0) begin
                        m_phase = PhScore;
                    end
                end
                PhScore: begin
                    m_over_left = Over;
                    if (int'(p1) >= Win) begin
                        m_winner = 1'b0;
                        m_phase  = PhOver;
                    end else if (int'(p2) >= Win) begin
                        m_winner = 1'b1;
                        m_phase  = PhOver;
                    end else begin
                        m_left  = Cd * Cf;
                        m_phase = PhCount;
                    end
                end
                PhOver: begin
                    if (se) new_match(cs);
                    else if (TimeoutEn && fd) begin
                        m_over_left--;
                        if (m_over_left == 0) begin
                            m_phase  = PhAttract;
                            m_winner = 1'b0;
                        end
                    end
                end
                PhPaused: begin
                    if (pe) m_phase = (m_ret == PhRally && pt == 2'd0) ? PhScore : m_ret;
                end
                default: m_phase = PhAttract;
            endcase
            m_ps  = sb;
            m_pp  = pb;
            m_ppt = int'(pt);
        end
        cd = (m_phase == PhCount || (m_phase == PhPaused && m_ret == PhCount)) ?
             (m_left + Cf - 1) / Cf : 0;
        e.at = cycle + 1;
        e.st = {3'(m_phase), 2'(cd), m_phase == PhPaused, m_phase == PhOver,
                m_winner && m_phase == PhOver};
        e.sp = sp;
        e.cs = cs;
        if (m_valid) exp_q.push_back(e);
    endtask

    task automatic run(input int n, input int per, input bit sb, input bit pb);
        for (int i = 0; i < n; i++) drive(1'b0, per != 0 && (i % per) == per - 1, sb, pb);
    endtask

    // One full point: play, finish (scores already final), back to idle.
    task automatic point(input logic [3:0] a, input logic [3:0] b);
        p1 = a;
        p2 = b;
        pt = 2'd1;
        run(2, 0, 1'b0, 1'b0);
        pt = 2'd2;
        run(2, 0, 1'b0, 1'b0);
        pt = 2'd0;
        run(3, 0, 1'b0, 1'b0);
    endtask

    always @(posedge clock) begin : monitor
        exp_t       e;
        logic [7:0] act;
        #1;
        if (exp_q.size() > 0 && exp_q[0].at == cycle) begin
            e   = exp_q.pop_front();
            act = {bus.seq_state, bus.countdown, bus.paused, bus.match_over,
                   bus.winner & bus.match_over};
            check("status{state,cd,paused,over,winner}", int'(act), int'(e.st));
            check("start_pt", int'(bus.start_pt), int'(e.sp));
            check("clear_scores", int'(bus.clear_scores), int'(e.cs));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus.frame_done = 1'b0;
        bus.start_btn  = 1'b0;
        bus.pause_btn  = 1'b0;
        bus.pt_state   = 2'd0;
        bus.p1_points  = 4'd0;
        bus.p2_points  = 4'd0;
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Held start gives one match start; 6 frames of countdown then the serve.
        run(10, 0, 1'b1, 1'b0);
        run(14, 2, 1'b0, 1'b0);
        // Ordinary point, no winner.
        point(4'd4, 4'd3);
        run(14, 2, 1'b0, 1'b0);
        // Player 2 reaches the winning score, then a restart.
        point(4'd4, 4'd9);
        run(3, 0, 1'b0, 1'b0);
        run(1, 0, 1'b1, 1'b0);
        run(2, 0, 1'b0, 1'b0);
        // Pause mid-countdown with frames arriving while paused.
        run(6, 2, 1'b0, 1'b0);
        run(1, 0, 1'b0, 1'b1);
        run(10, 2, 1'b0, 1'b1);
        run(1, 0, 1'b0, 1'b0);
        run(1, 0, 1'b0, 1'b1);
        run(1, 0, 1'b0, 1'b0);
        run(6, 2, 1'b0, 1'b0);
        // Pause edge coincides with the final frame of the countdown.
        point(4'd1, 4'd1);
        run(10, 2, 1'b0, 1'b0);
        run(1, 1, 1'b0, 1'b1);
        run(2, 0, 1'b0, 1'b0);
        run(1, 0, 1'b0, 1'b1);
        run(1, 0, 1'b0, 1'b0);
        run(4, 2, 1'b0, 1'b0);
        // Player 1 wins; GAME_OVER either holds or times out depending on the build.
        point(4'd9, 4'd1);
        run(600, 2, 1'b0, 1'b0);
        // Reset in mid-countdown with start and frame active: no pulses.
        run(1, 0, 1'b1, 1'b0);
        run(3, 2, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        run(3, 2, 1'b0, 1'b0);

        // Random play with a simple point FSM reacting to the serve.
        pt     = 2'd0;
        sb_lvl = 1'b0;
        pb_lvl = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5000; i++) begin
            bit r;
            r = ($urandom_range(0, 799) == 0);
            if (r) begin
                pt    = 2'd0;
                serve = 1'b0;
            end else if (serve) begin
                pt    = 2'd1;
                serve = 1'b0;
            end else if (pt == 2'd1 && $urandom_range(0, 7) == 0) begin
                pt = 2'd2;
                if ($urandom_range(0, 1) == 0) begin
                    if (p1 < 4'd9) p1 = p1 + 4'd1;
                end else begin
                    if (p2 < 4'd9) p2 = p2 + 4'd1;
                end
            end else if (pt == 2'd2 && $urandom_range(0, 1) == 0) begin
                pt = 2'd0;
            end
            if ($urandom_range(0, 49) == 0) sb_lvl = !sb_lvl;
            if ($urandom_range(0, 39) == 0) pb_lvl = !pb_lvl;
            drive(r, $urandom_range(0, 3) == 0, sb_lvl, pb_lvl);
        end

        run(4, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
